// File: rtl/slow_pkt_reader.sv
// slow_pkt_reader
// Drains 16-word event packets from the slow FIFO in whole-packet bursts,
// checks framing (PID word, zero padding in word3[15:0] and word11) and
// event-number continuity, and presents the decoded fields as registers
// that update together with a one-cycle pkt_valid strobe. A stream that
// has lost alignment is recovered by reading single words until the PID
// word is seen, after which the next burst fetches only the 15 words that
// follow it.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   fifo_dout/fifo_wd   FIFO read data (valid one cycle after fifo_rd) and level
//   fifo_rd             FIFO read enable
//   hold                blocks the start of any new burst or hunt read
//   pkt_valid           one-cycle strobe, pkt_* fields updated the same cycle
//   pkt_*               decoded packet fields
//   pid/fmt/seq_err_cnt saturating error counters
//   busy                high whenever the reader is not idle
//
// Build option
//   SLOW_PKT_SEQ_CHECK_EN  when defined, event-number continuity is checked
//                          and counted in seq_err_cnt; otherwise seq_err_cnt
//                          is constant 0.
module slow_pkt_reader #(
    parameter logic [31:0] PID           = 32'h4142504d,
    parameter int          PACKET_LEN    = 16,
    parameter int          FIFO_WD_WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [31:0]              fifo_dout,
    input  logic [FIFO_WD_WIDTH-1:0] fifo_wd,
    output logic                     fifo_rd,
    input  logic                     hold,
    output logic                     pkt_valid,
    output logic [15:0]              pkt_status,
    output logic [15:0]              pkt_evt_cnt,
    output logic [15:0]              pkt_x,
    output logic [15:0]              pkt_y,
    output logic [15:0]              pkt_s,
    output logic [31:0]              pkt_pwr_a,
    output logic [31:0]              pkt_pwr_b,
    output logic [31:0]              pkt_pwr_c,
    output logic [31:0]              pkt_pwr_d,
    output logic [15:0]              pkt_max_a,
    output logic [15:0]              pkt_max_b,
    output logic [15:0]              pkt_max_c,
    output logic [15:0]              pkt_max_d,
    output logic [15:0]              pkt_cal_x,
    output logic [15:0]              pkt_cal_y,
    output logic [31:0]              pkt_cal_pwr_a,
    output logic [31:0]              pkt_cal_pwr_b,
    output logic [31:0]              pkt_drift_a,
    output logic [31:0]              pkt_drift_b,
    output logic [15:0]              pid_err_cnt,
    output logic [15:0]              fmt_err_cnt,
    output logic [15:0]              seq_err_cnt,
    output logic                     busy
);

    localparam int CW = $clog2(PACKET_LEN);  // capture index width
    localparam int RW = CW + 1;              // read index must reach PACKET_LEN
    localparam logic [FIFO_WD_WIDTH-1:0] WD_FULL  = FIFO_WD_WIDTH'(PACKET_LEN);
    localparam logic [FIFO_WD_WIDTH-1:0] WD_HUNT  = FIFO_WD_WIDTH'(PACKET_LEN - 1);
    localparam logic [RW-1:0]            RD_END   = RW'(PACKET_LEN);
    localparam logic [CW-1:0]            LAST_IDX = CW'(PACKET_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_BURST, S_CHECK, S_HUNT_RD, S_HUNT_CMP
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] rd_idx_q;
    logic          cap_vld_q;
    logic [CW-1:0] cap_idx_q;
    logic          hunted_q;
    logic [31:0]   shadow_q [PACKET_LEN];

    logic start_ok, burst_rd, hunt_rd, hunt_hit, pid_ok, pad_ok, accept;
    logic [15:0] evt;

    // After a successful hunt word0 is already held, so only 15 words are needed.
    assign start_ok = !hold && (hunted_q ? (fifo_wd >= WD_HUNT) : (fifo_wd >= WD_FULL));
    assign burst_rd = (state_q == S_BURST) && (rd_idx_q < RD_END);
    assign hunt_rd  = (state_q == S_HUNT_RD) && !hold && (fifo_wd != '0);
    assign hunt_hit = (state_q == S_HUNT_CMP) && (fifo_dout == PID);
    assign pid_ok   = (shadow_q[0] == PID);
    assign pad_ok   = (shadow_q[3][15:0] == 16'h0000) && (shadow_q[11] == 32'h0);
    assign accept   = (state_q == S_CHECK) && pid_ok && pad_ok;
    assign evt      = shadow_q[1][15:0];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (start_ok) state_d = S_BURST;
            S_BURST:    if (cap_vld_q && (cap_idx_q == LAST_IDX)) state_d = S_CHECK;
            S_CHECK:    state_d = pid_ok ? S_IDLE : S_HUNT_RD;
            S_HUNT_RD:  if (hunt_rd) state_d = S_HUNT_CMP;
            S_HUNT_CMP: state_d = hunt_hit ? S_IDLE : S_HUNT_RD;
            default:    state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state; fifo_rd drops as soon as reset clears the state.
    always_comb begin
        fifo_rd = burst_rd || hunt_rd;
        busy    = (state_q != S_IDLE);
    end

    // Read pipeline: the capture index trails the read index by one cycle,
    // matching the FIFO's one-cycle read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_idx_q  <= '0;
            cap_vld_q <= 1'b0;
            cap_idx_q <= '0;
            hunted_q  <= 1'b0;
            for (int i = 0; i < PACKET_LEN; i++) shadow_q[i] <= '0;
        end else begin
            if (state_q == S_IDLE)
                rd_idx_q <= hunted_q ? RW'(1) : '0;
            else if (burst_rd)
                rd_idx_q <= rd_idx_q + RW'(1);
            cap_vld_q <= burst_rd;
            cap_idx_q <= rd_idx_q[CW-1:0];
            if (cap_vld_q)
                shadow_q[cap_idx_q] <= fifo_dout;
            else if (hunt_hit)
                shadow_q[0] <= fifo_dout;
            // The hunted PID is consumed by whatever CHECK follows, good or bad.
            if (hunt_hit)
                hunted_q <= 1'b1;
            else if (state_q == S_CHECK)
                hunted_q <= 1'b0;
        end
    end

    // Decoded outputs and framing error counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_valid     <= 1'b0;
            pkt_status    <= '0;
            pkt_evt_cnt   <= '0;
            pkt_x         <= '0;
            pkt_y         <= '0;
            pkt_s         <= '0;
            pkt_pwr_a     <= '0;
            pkt_pwr_b     <= '0;
            pkt_pwr_c     <= '0;
            pkt_pwr_d     <= '0;
            pkt_max_a     <= '0;
            pkt_max_b     <= '0;
            pkt_max_c     <= '0;
            pkt_max_d     <= '0;
            pkt_cal_x     <= '0;
            pkt_cal_y     <= '0;
            pkt_cal_pwr_a <= '0;
            pkt_cal_pwr_b <= '0;
            pkt_drift_a   <= '0;
            pkt_drift_b   <= '0;
            pid_err_cnt   <= '0;
            fmt_err_cnt   <= '0;
        end else begin
            pkt_valid <= accept;
            if (accept) begin
                pkt_status    <= shadow_q[1][31:16];
                pkt_evt_cnt   <= evt;
                pkt_x         <= shadow_q[2][31:16];
                pkt_y         <= shadow_q[2][15:0];
                pkt_s         <= shadow_q[3][31:16];
                pkt_pwr_a     <= shadow_q[4];
                pkt_pwr_b     <= shadow_q[5];
                pkt_pwr_c     <= shadow_q[6];
                pkt_pwr_d     <= shadow_q[7];
                pkt_max_a     <= shadow_q[8][31:16];
                pkt_max_b     <= shadow_q[8][15:0];
                pkt_max_c     <= shadow_q[9][31:16];
                pkt_max_d     <= shadow_q[9][15:0];
                pkt_cal_x     <= shadow_q[10][31:16];
                pkt_cal_y     <= shadow_q[10][15:0];
                pkt_cal_pwr_a <= shadow_q[12];
                pkt_cal_pwr_b <= shadow_q[13];
                pkt_drift_a   <= shadow_q[14];
                pkt_drift_b   <= shadow_q[15];
            end
            if ((state_q == S_CHECK) && !pid_ok && (pid_err_cnt != 16'hFFFF))
                pid_err_cnt <= pid_err_cnt + 16'd1;
            if ((state_q == S_CHECK) && pid_ok && !pad_ok && (fmt_err_cnt != 16'hFFFF))
                fmt_err_cnt <= fmt_err_cnt + 16'd1;
        end
    end

`ifdef SLOW_PKT_SEQ_CHECK_EN
    logic        first_q;
    logic [15:0] last_q;
    logic [15:0] seq_cnt_q;
    logic        seq_ok;

    // evt == 0 is a software-initiated restart of the event numbering.
    assign seq_ok = first_q || (evt == 16'h0000) || (evt == last_q + 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q   <= 1'b1;
            last_q    <= '0;
            seq_cnt_q <= '0;
        end else if (accept) begin
            first_q <= 1'b0;
            last_q  <= evt;
            if (!seq_ok && (seq_cnt_q != 16'hFFFF))
                seq_cnt_q <= seq_cnt_q + 16'd1;
        end
    end

    assign seq_err_cnt = seq_cnt_q;
`else
    assign seq_err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_slow_pkt_reader.sv
module tb_slow_pkt_reader;

    localparam logic [31:0] PID = 32'h4142504d;

    typedef logic [15:0][31:0] pkt_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] fifo_dout = '0;
    logic [5:0]  fifo_wd;
    logic        fifo_rd;
    logic        hold = 1'b0;
    logic        pkt_valid;
    logic [15:0] pkt_status, pkt_evt_cnt, pkt_x, pkt_y, pkt_s;
    logic [31:0] pkt_pwr_a, pkt_pwr_b, pkt_pwr_c, pkt_pwr_d;
    logic [15:0] pkt_max_a, pkt_max_b, pkt_max_c, pkt_max_d, pkt_cal_x, pkt_cal_y;
    logic [31:0] pkt_cal_pwr_a, pkt_cal_pwr_b, pkt_drift_a, pkt_drift_b;
    logic [15:0] pid_err_cnt, fmt_err_cnt, seq_err_cnt;
    logic        busy;

    slow_pkt_reader dut (
        .clk(clk), .rst_n(rst_n), .fifo_dout(fifo_dout), .fifo_wd(fifo_wd),
        .fifo_rd(fifo_rd), .hold(hold), .pkt_valid(pkt_valid),
        .pkt_status(pkt_status), .pkt_evt_cnt(pkt_evt_cnt), .pkt_x(pkt_x), .pkt_y(pkt_y),
        .pkt_s(pkt_s), .pkt_pwr_a(pkt_pwr_a), .pkt_pwr_b(pkt_pwr_b), .pkt_pwr_c(pkt_pwr_c),
        .pkt_pwr_d(pkt_pwr_d), .pkt_max_a(pkt_max_a), .pkt_max_b(pkt_max_b),
        .pkt_max_c(pkt_max_c), .pkt_max_d(pkt_max_d), .pkt_cal_x(pkt_cal_x),
        .pkt_cal_y(pkt_cal_y), .pkt_cal_pwr_a(pkt_cal_pwr_a), .pkt_cal_pwr_b(pkt_cal_pwr_b),
        .pkt_drift_a(pkt_drift_a), .pkt_drift_b(pkt_drift_b),
        .pid_err_cnt(pid_err_cnt), .fmt_err_cnt(fmt_err_cnt), .seq_err_cnt(seq_err_cnt),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // All decoded fields in word order, for one-shot comparison.
    logic [431:0] dut_vec;
    assign dut_vec = {pkt_status, pkt_evt_cnt, pkt_x, pkt_y, pkt_s,
                      pkt_pwr_a, pkt_pwr_b, pkt_pwr_c, pkt_pwr_d,
                      pkt_max_a, pkt_max_b, pkt_max_c, pkt_max_d, pkt_cal_x, pkt_cal_y,
                      pkt_cal_pwr_a, pkt_cal_pwr_b, pkt_drift_a, pkt_drift_b};

    // FIFO model: writes come only from the stimulus, reads only from this block.
    logic [31:0] mem [256];
    int wp = 0;
    int rp = 0;
    int underflow = 0;
    assign fifo_wd = 6'(wp - rp);

    always @(posedge clk) begin
        if (fifo_rd) begin
            if (rp < wp) fifo_dout <= mem[rp];
            else         underflow <= underflow + 1;
            rp <= rp + 1;
        end
    end

    // Bench state and reference model
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_valid_cyc = -1;
    logic [31:0]  mq[$];
    logic [431:0] exp_q[$];
    logic [431:0] last_vec = '0;
    logic         m_hunting = 0, m_hunted = 0, m_first = 1;
    logic [15:0]  m_last = 0, m_pid = 0, m_fmt = 0, m_seq = 0;

    task automatic chk(input string tag, input logic [431:0] obs, input logic [431:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [431:0] fields(input pkt_t p);
        return {p[1], p[2], p[3][31:16], p[4], p[5], p[6], p[7],
                p[8], p[9], p[10], p[12], p[13], p[14], p[15]};
    endfunction

    function automatic logic [31:0] rnd_word();
        logic [31:0] w;
        do w = $urandom; while (w == PID);
        return w;
    endfunction

    // bad: 0 clean, 1 word11 non-zero, 2 word3 low half non-zero
    function automatic pkt_t mk_pkt(input logic [15:0] status, input logic [15:0] evt,
                                    input int bad);
        pkt_t p;
        for (int i = 0; i < 16; i++) p[i] = rnd_word();
        p[0] = PID;
        p[1] = {status, evt};
        p[3][15:0] = (bad == 2) ? 16'h0001 : 16'h0000;
        p[11] = (bad == 1) ? 32'h1 : 32'h0;
        return p;
    endfunction

    task automatic push_word(input logic [31:0] w);
        mem[wp] = w;
        wp = wp + 1;
        mq.push_back(w);
    endtask

    task automatic push_pkt(input pkt_t p);
        for (int i = 0; i < 16; i++) push_word(p[i]);
    endtask

    // Reference: consume the word stream packet by packet. A bad PID switches
    // to hunting, which discards words until a PID is found; that PID then
    // serves as word0 of the next packet.
    task automatic model_run();
        pkt_t p;
        int need;
        logic [31:0] w;
        while (1) begin
            while (m_hunting && mq.size() > 0) begin
                w = mq.pop_front();
                if (w == PID) begin
                    m_hunting = 0;
                    m_hunted = 1;
                end
            end
            if (m_hunting) return;
            need = m_hunted ? 15 : 16;
            if (mq.size() < need) return;
            for (int i = 0; i < 16; i++) begin
                if (m_hunted && i == 0) p[i] = PID;
                else                    p[i] = mq.pop_front();
            end
            m_hunted = 0;
            if (p[0] != PID) begin
                if (m_pid != 16'hFFFF) m_pid++;
                m_hunting = 1;
            end else if (p[3][15:0] != 0 || p[11] != 0) begin
                if (m_fmt != 16'hFFFF) m_fmt++;
            end else begin
                exp_q.push_back(fields(p));
`ifdef SLOW_PKT_SEQ_CHECK_EN
                if (!(m_first || p[1][15:0] == 16'h0 || p[1][15:0] == m_last + 16'd1))
                    if (m_seq != 16'hFFFF) m_seq++;
`endif
                m_first = 0;
                m_last = p[1][15:0];
            end
        end
    endtask

    // One cycle step; every accepted packet is compared as it appears.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (rst_n && pkt_valid) begin
            last_valid_cyc = cyc;
            chk("pkt_valid_expected", 432'(exp_q.size() != 0), 432'(1));
            if (exp_q.size() != 0) begin
                last_vec = exp_q.pop_front();
                chk("pkt_fields", dut_vec, last_vec);
            end
        end
    endtask

    task automatic settle(input string tag);
        int quiet = 0;
        int k = 0;
        while (quiet < 25 && k < 3000) begin
            tick();
            k++;
            if (!busy && !fifo_rd) quiet++;
            else                   quiet = 0;
        end
        chk({tag, "_settle"}, 432'(quiet >= 25), 432'(1));
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_pid_err"}, 432'(pid_err_cnt), 432'(m_pid));
        chk({tag, "_fmt_err"}, 432'(fmt_err_cnt), 432'(m_fmt));
        chk({tag, "_seq_err"}, 432'(seq_err_cnt), 432'(m_seq));
        chk({tag, "_outputs"}, dut_vec, last_vec);
        chk({tag, "_pending"}, 432'(exp_q.size()), 432'(0));
        chk({tag, "_fifo_left"}, 432'(fifo_wd), 432'(mq.size()));
    endtask

    initial begin
        pkt_t p;
        int n, nrd, c0, rp0;

        // Reset state
        repeat (3) tick();
        chk("rst_outputs", dut_vec, 432'(0));
        chk("rst_ctrl", 432'({fifo_rd, pkt_valid, busy}), 432'(0));
        chk("rst_cnts", 432'({pid_err_cnt, fmt_err_cnt, seq_err_cnt}), 432'(0));
        rst_n = 1'b1;
        tick();

        // Good packet: latency and burst length
        p = mk_pkt(16'h8001, 16'd5, 0);
        p[2] = {16'h0100, 16'hFF00};
        push_pkt(p);
        model_run();
        n = 0;
        while (!fifo_rd && n < 50) begin tick(); n++; end
        c0 = cyc;
        nrd = 0;
        while (fifo_rd && nrd < 40) begin nrd++; tick(); end
        n = 0;
        while (last_valid_cyc < c0 && n < 40) begin tick(); n++; end
        chk("t1_read_cycles", 432'(nrd), 432'(16));
        chk("t1_valid_latency", 432'(last_valid_cyc - c0), 432'(18));
        chk("t1_evt_cnt", 432'(pkt_evt_cnt), 432'(16'd5));
        chk("t1_status", 432'(pkt_status), 432'(16'h8001));
        chk("t1_y", 432'(pkt_y), 432'(16'hFF00));
        settle("t1");
        check_state("t1");

        // Stray words: misaligned burst, hunt, then a hunted 15-word burst
        for (int i = 0; i < 3; i++) push_word(rnd_word());
        push_pkt(mk_pkt($urandom, 16'd40, 0));
        push_pkt(mk_pkt($urandom, 16'd6, 0));
        model_run();
        settle("t2");
        chk("t2_pid_err_one", 432'(pid_err_cnt), 432'(1));
        chk("t2_evt_cnt", 432'(pkt_evt_cnt), 432'(16'd6));
        check_state("t2");

        // Bad padding in word11, then in word3, then a sequence gap
        push_pkt(mk_pkt($urandom, 16'd99, 1));
        model_run();
        settle("t3a");
        chk("t3a_fmt_err_one", 432'(fmt_err_cnt), 432'(1));
        check_state("t3a");
        push_pkt(mk_pkt($urandom, 16'd98, 2));
        model_run();
        settle("t3b");
        check_state("t3b");
        push_pkt(mk_pkt($urandom, 16'd7, 0));
        push_pkt(mk_pkt($urandom, 16'd8, 0));
        model_run();
        settle("t3c");
        push_pkt(mk_pkt($urandom, 16'd10, 0));
        push_pkt(mk_pkt($urandom, 16'd0, 0));
        model_run();
        settle("t3d");
        check_state("t3d");

        // FIFO level and hold
        p = mk_pkt($urandom, 16'd1, 0);
        for (int i = 0; i < 15; i++) push_word(p[i]);
        n = 0;
        repeat (20) begin tick(); if (fifo_rd) n++; end
        chk("t4_no_read_at_15", 432'(n), 432'(0));
        hold = 1'b1;
        push_word(p[15]);
        model_run();
        n = 0;
        repeat (20) begin tick(); if (fifo_rd) n++; end
        chk("t4_no_read_on_hold", 432'(n), 432'(0));
        hold = 1'b0;
        tick();
        chk("t4_burst_next_cycle", 432'(fifo_rd), 432'(1));
        hold = 1'b1;  // must not cut the burst short
        nrd = 1;
        repeat (20) begin tick(); if (fifo_rd) nrd++; end
        chk("t4_burst_ignores_hold", 432'(nrd), 432'(16));
        hold = 1'b0;
        settle("t4");
        check_state("t4");

        // Reset after 8 reads of a burst
        rp0 = rp;
        push_pkt(mk_pkt($urandom, 16'd2, 0));
        n = 0;
        while ((rp - rp0) < 8 && n < 100) begin tick(); n++; end
        rst_n = 1'b0;
        #1;
        chk("t5_rst_fifo_rd", 432'(fifo_rd), 432'(0));
        chk("t5_rst_outputs", dut_vec, 432'(0));
        chk("t5_rst_ctrl", 432'({pkt_valid, busy, pid_err_cnt, fmt_err_cnt, seq_err_cnt}), 432'(0));
        for (int i = 0; i < 8; i++) void'(mq.pop_front());
        m_hunting = 0; m_hunted = 0; m_first = 1;
        m_last = 0; m_pid = 0; m_fmt = 0; m_seq = 0;
        exp_q.delete();
        last_vec = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        push_pkt(mk_pkt($urandom, 16'd3, 0));
        push_pkt(mk_pkt($urandom, 16'd4, 0));
        model_run();
        settle("t5");
        chk("t5_pid_err_one", 432'(pid_err_cnt), 432'(1));
        chk("t5_evt_cnt", 432'(pkt_evt_cnt), 432'(16'd4));
        check_state("t5");
        chk("no_underflow", 432'(underflow), 432'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
